// File: rtl/core_pkg.sv
// Shared core types for the memory port: master identifiers and the
// request payload that travels from a master to the memory.
package core_pkg;

   typedef enum logic {
      MST_INSTR = 1'b0,
      MST_DATA  = 1'b1
   } mem_master_e;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   // Instruction fetches always read a full word.
   localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_id_fifo.sv
// Generic synchronous FIFO. A count register one bit wider than the
// pointers tells full from empty. Pushes while full and pops while empty
// are ignored. The storage array has no reset; only pointers and count do.
module id_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = store[rd_ptr];

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage, written at the tail on an accepted push.
   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and data
// access. Arbitration is combinational; the ID of every accepted request is
// queued so in-order responses are steered back to the issuing master.
module mem_port_arbiter
   import core_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int FIXED_PRIO      = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        resp_err_o
);

   mem_master_e winner;
   mem_master_e last_winner;
   mem_master_e head_id;
   mem_req_t    instr_txn;
   mem_req_t    data_txn;
   mem_req_t    win_txn;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_head;
   logic        handshake;
   logic        resp_pop;
   logic        resp_err;

   assign instr_txn = '{we: 1'b0, be: BE_WORD, addr: instr_addr_i, wdata: 32'h0};
   assign data_txn  = '{we: data_we_i, be: data_be_i, addr: data_addr_i, wdata: data_wdata_i};

   // Pick the winner: a lone requester wins; a tie goes to data or alternates.
   always_comb begin
      winner = MST_INSTR;
      if (data_req_i && !instr_req_i) begin
         winner = MST_DATA;
      end else if (data_req_i && instr_req_i) begin
         if (FIXED_PRIO != 0) winner = MST_DATA;
         else                 winner = (last_winner == MST_DATA) ? MST_INSTR : MST_DATA;
      end
   end

   assign win_txn     = (winner == MST_DATA) ? data_txn : instr_txn;
   assign mem_req_o   = (instr_req_i | data_req_i) & ~fifo_full;
   assign mem_we_o    = win_txn.we;
   assign mem_be_o    = win_txn.be;
   assign mem_addr_o  = win_txn.addr;
   assign mem_wdata_o = win_txn.wdata;

   assign handshake   = mem_req_o & mem_gnt_i;
   assign instr_gnt_o = handshake & (winner == MST_INSTR);
   assign data_gnt_o  = handshake & (winner == MST_DATA);

   // Responses are only attributed when a transaction is actually outstanding.
   assign head_id        = mem_master_e'(fifo_head);
   assign resp_pop       = mem_rvalid_i & ~fifo_empty;
   assign instr_rvalid_o = resp_pop & (head_id == MST_INSTR);
   assign data_rvalid_o  = resp_pop & (head_id == MST_DATA);
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;
   assign resp_err_o     = resp_err;

   id_fifo #(
      .WIDTH (1),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .push    (handshake),
      .pop     (resp_pop),
      .wr_data (winner),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Round-robin history moves only when a request is actually accepted.
   always_ff @(posedge clk_i) begin
      if (rst_i)          last_winner <= MST_DATA;
      else if (handshake) last_winner <= winner;
   end

   // Sticky flag for a response that arrives with nothing outstanding.
   always_ff @(posedge clk_i) begin
      if (rst_i)                           resp_err <= 1'b0;
      else if (mem_rvalid_i && fifo_empty) resp_err <= 1'b1;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations
// plus a randomized run against a queue-based reference model.
module tb_mem_port_arbiter;
   import core_pkg::*;

   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        instr_req_i, data_req_i, data_we_i, mem_gnt_i, mem_rvalid_i;
   logic [31:0] instr_addr_i, data_addr_i, data_wdata_i, mem_rdata_i;
   logic [3:0]  data_be_i;
   logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
   logic        mem_req_o, mem_we_o, resp_err_o;
   logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;

   logic        f_instr_req_i, f_data_req_i, f_data_we_i, f_mem_gnt_i, f_mem_rvalid_i;
   logic [31:0] f_instr_addr_i, f_data_addr_i, f_data_wdata_i, f_mem_rdata_i;
   logic [3:0]  f_data_be_i;
   logic        f_instr_gnt_o, f_instr_rvalid_o, f_data_gnt_o, f_data_rvalid_o;
   logic        f_mem_req_o, f_mem_we_o, f_resp_err_o;
   logic [31:0] f_instr_rdata_o, f_data_rdata_o, f_mem_addr_o, f_mem_wdata_o;
   logic [3:0]  f_mem_be_o;

   int checks = 0;
   int errors = 0;

   // Reference model state: the queue of outstanding master IDs.
   mem_master_e mq[$];
   mem_master_e m_last;
   bit          m_err;
   logic [5:0]  exp_ctl;
   mem_req_t    exp_txn;
   bit          exp_hs;
   mem_master_e exp_win;

   logic [5:0] obs, f_obs;
   mem_req_t   obs_txn, f_txn;
   assign obs     = {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, resp_err_o};
   assign f_obs   = {f_mem_req_o, f_instr_gnt_o, f_data_gnt_o, f_instr_rvalid_o, f_data_rvalid_o, f_resp_err_o};
   assign obs_txn = {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};
   assign f_txn   = {f_mem_we_o, f_mem_be_o, f_mem_addr_o, f_mem_wdata_o};

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .FIXED_PRIO(0)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .resp_err_o(resp_err_o));

   mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .FIXED_PRIO(1)) dut_fp (
      .clk_i(clk), .rst_i(rst_i),
      .instr_req_i(f_instr_req_i), .instr_addr_i(f_instr_addr_i), .instr_gnt_o(f_instr_gnt_o),
      .instr_rvalid_o(f_instr_rvalid_o), .instr_rdata_o(f_instr_rdata_o),
      .data_req_i(f_data_req_i), .data_we_i(f_data_we_i), .data_be_i(f_data_be_i),
      .data_addr_i(f_data_addr_i), .data_wdata_i(f_data_wdata_i), .data_gnt_o(f_data_gnt_o),
      .data_rvalid_o(f_data_rvalid_o), .data_rdata_o(f_data_rdata_o),
      .mem_req_o(f_mem_req_o), .mem_we_o(f_mem_we_o), .mem_be_o(f_mem_be_o), .mem_addr_o(f_mem_addr_o),
      .mem_wdata_o(f_mem_wdata_o), .mem_gnt_i(f_mem_gnt_i), .mem_rvalid_i(f_mem_rvalid_i),
      .mem_rdata_i(f_mem_rdata_i), .resp_err_o(f_resp_err_o));

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                        input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
                        input logic g, input logic rv, input logic [31:0] rd);
      instr_req_i = ir; instr_addr_i = ia; data_req_i = dr; data_we_i = dwe; data_be_i = dbe;
      data_addr_i = da; data_wdata_i = dwd; mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
   endtask

   task automatic f_drive(input logic ir, input logic dr, input logic g, input logic rv);
      f_instr_req_i = ir; f_instr_addr_i = 32'h0000_0010; f_data_req_i = dr; f_data_we_i = 1'b1;
      f_data_be_i = 4'b1100; f_data_addr_i = 32'h0000_0500; f_data_wdata_i = 32'hA5A5_0000;
      f_mem_gnt_i = g; f_mem_rvalid_i = rv; f_mem_rdata_i = 32'h0BAD_F00D;
   endtask

   // Expected outputs for the current inputs, from the arbitration rules.
   task automatic model_eval();
      bit          full;
      bit          pop;
      mem_master_e head;
      full = (mq.size() >= MAXO);
      if (instr_req_i && data_req_i) exp_win = (m_last == MST_DATA) ? MST_INSTR : MST_DATA;
      else                           exp_win = data_req_i ? MST_DATA : MST_INSTR;
      exp_hs = (instr_req_i | data_req_i) && !full && mem_gnt_i;
      pop    = mem_rvalid_i && (mq.size() > 0);
      head   = pop ? mq[0] : MST_INSTR;
      exp_ctl = {(instr_req_i | data_req_i) && !full, exp_hs && exp_win == MST_INSTR,
                 exp_hs && exp_win == MST_DATA, pop && head == MST_INSTR,
                 pop && head == MST_DATA, m_err};
      if (exp_win == MST_DATA) exp_txn = '{data_we_i, data_be_i, data_addr_i, data_wdata_i};
      else                     exp_txn = '{1'b0, 4'hF, instr_addr_i, 32'h0};
   endtask

   // Advance the model to what the coming clock edge does.
   task automatic model_commit();
      if (rst_i) begin
         mq.delete();
         m_last = MST_DATA;
         m_err  = 1'b0;
      end else begin
         if (mem_rvalid_i) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else               m_err = 1'b1;
         end
         if (exp_hs) begin
            mq.push_back(exp_win);
            m_last = exp_win;
         end
      end
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_i = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      model_commit();
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      r = $urandom;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         rst_i = 1'b1;
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0, r);
         f_drive(0, 0, 0, 0);
         settle();
         if (i == 1) begin
            checks++;
            if (obs !== 6'b000000) begin errors++; $display("FAIL reset_ctl got=%b want=%b", obs, 6'b0); end
            checks++;
            if (instr_rdata_o !== r || data_rdata_o !== r) begin
               errors++; $display("FAIL reset_rdata got=%h/%h want=%h", instr_rdata_o, data_rdata_o, r);
            end
         end
         model_commit();
      end
      @(negedge clk);
      rst_i = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checks++;
      if (obs !== 6'b000000 || f_obs !== 6'b000000) begin
         errors++; $display("FAIL post_reset_ctl got=%b/%b want=000000", obs, f_obs);
      end
      model_commit();
   endtask

   task automatic test_instr_fetch();
      @(negedge clk);
      drive(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0);
      settle();
      checks++;
      if (obs !== 6'b110000 || obs_txn !== mem_req_t'({1'b0, 4'hF, 32'h0, 32'h0})) begin
         errors++; $display("FAIL fetch0 got=%b %h want=110000", obs, obs_txn);
      end
      model_commit();
      @(negedge clk);
      drive(1, 32'h4, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0013);
      settle();
      checks++;
      if (obs !== 6'b110100 || instr_rdata_o !== 32'h0000_0013 || mem_addr_o !== 32'h4) begin
         errors++; $display("FAIL fetch4 got=%b rdata=%h addr=%h want=110100 00000013 4", obs, instr_rdata_o, mem_addr_o);
      end
      model_commit();
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0093);
      settle();
      checks++;
      if (obs !== 6'b000100 || instr_rdata_o !== 32'h0000_0093) begin
         errors++; $display("FAIL fetch_resp2 got=%b rdata=%h want=000100 00000093", obs, instr_rdata_o);
      end
      model_commit();
   endtask

   task automatic test_round_robin();
      logic [5:0] want;
      mem_req_t   want_txn;
      bit         prev_data;
      do_reset();
      prev_data = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         drive(1, 32'h40, 1, 1, 4'b0101, 32'h200, 32'h55, 1, k > 0, 32'h1234_0000 + k);
         settle();
         want = {1'b1, (k % 2) == 0, (k % 2) == 1, k > 0 && !prev_data, k > 0 && prev_data, 1'b0};
         want_txn = ((k % 2) == 1) ? mem_req_t'({1'b1, 4'b0101, 32'h200, 32'h55})
                                   : mem_req_t'({1'b0, 4'hF, 32'h40, 32'h0});
         checks++;
         if (obs !== want || obs_txn !== want_txn) begin
            errors++; $display("FAIL rr_cycle%0d got=%b %h want=%b %h", k, obs, obs_txn, want, want_txn);
         end
         prev_data = (k % 2) == 1;
         model_commit();
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      settle();
      checks++;
      if (obs !== 6'b000010) begin errors++; $display("FAIL rr_drain got=%b want=000010", obs); end
      model_commit();
   endtask

   task automatic test_fixed_prio();
      logic [5:0] want;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < 4)       f_drive(1, 1, 1, k > 0);
         else if (k == 4) f_drive(1, 0, 1, 1);
         else             f_drive(0, 0, 0, 1);
         #1;
         if (k < 4)       want = {1'b1, 1'b0, 1'b1, 1'b0, k > 0, 1'b0};
         else if (k == 4) want = 6'b110010;
         else             want = 6'b000100;
         checks++;
         if (f_obs !== want) begin errors++; $display("FAIL fixed_prio%0d got=%b want=%b", k, f_obs, want); end
         if (k < 4) begin
            checks++;
            if (f_txn !== mem_req_t'({1'b1, 4'b1100, 32'h500, 32'hA5A5_0000}) || f_data_rdata_o !== 32'h0BAD_F00D) begin
               errors++; $display("FAIL fixed_prio_txn%0d got=%h rdata=%h", k, f_txn, f_data_rdata_o);
            end
         end
      end
      @(negedge clk);
      f_drive(0, 0, 0, 0);
   endtask

   task automatic test_full();
      logic [5:0] want [7];
      want = '{6'b110000, 6'b101000, 6'b000000, 6'b000100, 6'b110000, 6'b000010, 6'b000100};
      do_reset();
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         case (k)
            0:       drive(1, 32'h80, 0, 0, 4'hF, 32'h300, 0, 1, 0, 0);
            1:       drive(0, 32'h80, 1, 0, 4'hF, 32'h300, 0, 1, 0, 0);
            2:       drive(1, 32'h84, 1, 0, 4'hF, 32'h304, 0, 1, 0, 0);
            3:       drive(1, 32'h84, 1, 0, 4'hF, 32'h304, 0, 1, 1, 32'h1);
            4:       drive(1, 32'h84, 0, 0, 4'hF, 32'h304, 0, 1, 0, 0);
            default: drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2);
         endcase
         settle();
         checks++;
         if (obs !== want[k]) begin errors++; $display("FAIL full_cycle%0d got=%b want=%b", k, obs, want[k]); end
         model_commit();
      end
   endtask

   task automatic test_store();
      logic [31:0] rd;
      rd = $urandom;
      @(negedge clk);
      drive(0, 0, 1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 1, 0, 0);
      settle();
      checks++;
      if (obs !== 6'b101000 || obs_txn !== mem_req_t'({1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF})) begin
         errors++; $display("FAIL store_req got=%b %h want=101000", obs, obs_txn);
      end
      model_commit();
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, rd);
      settle();
      checks++;
      if (obs !== 6'b000010 || data_rdata_o !== rd) begin
         errors++; $display("FAIL store_ack got=%b rdata=%h want=000010 %h", obs, data_rdata_o, rd);
      end
      model_commit();
   endtask

   task automatic test_error();
      logic [5:0] want [9];
      want = '{6'b000000, 6'b000001, 6'b000001, 6'b110001, 6'b000001,
               6'b000000, 6'b000000, 6'b000001, 6'b110001};
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         rst_i = (k == 4);
         case (k)
            0, 6:    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hE);
            3:       drive(1, 32'hC0, 0, 0, 0, 0, 0, 1, 0, 0);
            8:       drive(1, 32'hC4, 1, 0, 4'hF, 32'h600, 0, 1, 0, 0);
            default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         endcase
         settle();
         checks++;
         if (obs !== want[k]) begin errors++; $display("FAIL error_cycle%0d got=%b want=%b", k, obs, want[k]); end
         model_commit();
      end
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         rst_i = ($urandom_range(0, 49) == 0);
         drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 1),
               4'($urandom), $urandom, $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) != 0, $urandom);
         settle();
         checks++;
         if (obs !== exp_ctl) begin errors++; $display("FAIL rand_ctl%0d got=%b want=%b", k, obs, exp_ctl); end
         if (exp_ctl[5]) begin
            checks++;
            if (obs_txn !== exp_txn) begin errors++; $display("FAIL rand_txn%0d got=%h want=%h", k, obs_txn, exp_txn); end
         end
         if (instr_rdata_o !== mem_rdata_i || data_rdata_o !== mem_rdata_i) begin
            checks++; errors++;
            $display("FAIL rand_rdata%0d got=%h/%h want=%h", k, instr_rdata_o, data_rdata_o, mem_rdata_i);
         end else begin
            checks++;
         end
         model_commit();
      end
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      f_drive(0, 0, 0, 0);
      m_last = MST_DATA;
      m_err  = 1'b0;
      test_reset();
      test_instr_fetch();
      test_round_robin();
      test_fixed_prio();
      test_full();
      test_store();
      test_error();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
